// File: rtl/vga_source_arbiter_if.sv
// Video source arbitration bundle: raw syncs, requests and two pixel sources in,
// grant, delayed syncs, frame pulse and arbitrated pixels out.
interface vga_source_arbiter_if #(
  parameter int unsigned VIDEO_WIDTH = 3
);
  logic                   i_HSync;
  logic                   i_VSync;
  logic [1:0]             i_Req;
  logic [VIDEO_WIDTH-1:0] i_Red0;
  logic [VIDEO_WIDTH-1:0] i_Grn0;
  logic [VIDEO_WIDTH-1:0] i_Blu0;
  logic [VIDEO_WIDTH-1:0] i_Red1;
  logic [VIDEO_WIDTH-1:0] i_Grn1;
  logic [VIDEO_WIDTH-1:0] i_Blu1;
  logic [1:0]             o_Gnt;
  logic                   o_HSync;
  logic                   o_VSync;
  logic [VIDEO_WIDTH-1:0] o_Red_Video;
  logic [VIDEO_WIDTH-1:0] o_Grn_Video;
  logic [VIDEO_WIDTH-1:0] o_Blu_Video;
  logic                   o_Frame_Start;

  // Driver side (video sources and timing generator).
  modport master (
    output i_HSync, i_VSync, i_Req,
    output i_Red0, i_Grn0, i_Blu0, i_Red1, i_Grn1, i_Blu1,
    input  o_Gnt, o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Start
  );

  // Arbiter side.
  modport slave (
    input  i_HSync, i_VSync, i_Req,
    input  i_Red0, i_Grn0, i_Blu0, i_Red1, i_Grn1, i_Blu1,
    output o_Gnt, o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Start
  );
endinterface

// File: rtl/vga_source_arbiter.sv
// Frame-synchronous arbiter choosing which of two pixel sources drives the video path.
// Define VGA_ARB_PREEMPT_EN to let requester 0 preempt owner 1 at a frame start.
module vga_source_arbiter #(
  parameter int unsigned VIDEO_WIDTH  = 3,
  parameter int unsigned BLANK_FRAMES = 1
) (
  input logic                    i_Clk,
  input logic                    i_Rst_L,
  vga_source_arbiter_if.slave    bus_io
);

  localparam logic [3:0] BlankFrames = 4'(BLANK_FRAMES);
  localparam bit         BlankEn     = (BLANK_FRAMES != 0);
`ifdef VGA_ARB_PREEMPT_EN
  localparam bit         PreemptEn   = 1'b1;
`else
  localparam bit         PreemptEn   = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StBlank} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             blank_cnt_q, blank_cnt_d;
  logic                   vsync_q;
  logic                   hsync_q;
  logic                   fs_q;
  logic                   fs;
  logic                   owner_drop;
  logic                   vid_on;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;

  // Fixed priority: requester 0 wins a simultaneous request.
  function automatic state_e arbitrate(input logic [1:0] req);
    if (req[0]) begin
      return StOwn0;
    end else if (req[1]) begin
      return StOwn1;
    end
    return StIdle;
  endfunction

  // vsync_q doubles as the VSync history register and the delayed output sync.
  assign fs = bus_io.i_VSync & ~vsync_q;

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    owner_drop  = 1'b0;
    if (fs) begin
      unique case (state_q)
        StIdle:  state_d = arbitrate(bus_io.i_Req);
        StOwn0:  owner_drop = ~bus_io.i_Req[0];
        StOwn1:  owner_drop = ~bus_io.i_Req[1] | (PreemptEn & bus_io.i_Req[0]);
        StBlank: begin
          blank_cnt_d = blank_cnt_q + 4'd1;
          if (blank_cnt_d == BlankFrames) begin
            blank_cnt_d = 4'd0;
            state_d     = arbitrate(bus_io.i_Req);
          end
        end
        default: state_d = StIdle;
      endcase
      // Without blank frames the handover happens within the same frame start.
      if (owner_drop) begin
        if (BlankEn) begin
          state_d     = StBlank;
          blank_cnt_d = 4'd0;
        end else begin
          state_d     = arbitrate(bus_io.i_Req);
        end
      end
    end
  end

  // Pixels follow the next-state owner so they line up with the registered grant.
  assign vid_on = bus_io.i_HSync & bus_io.i_VSync;

  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (vid_on) begin
      unique case (state_d)
        StOwn0: begin
          red_d = bus_io.i_Red0;
          grn_d = bus_io.i_Grn0;
          blu_d = bus_io.i_Blu0;
        end
        StOwn1: begin
          red_d = bus_io.i_Red1;
          grn_d = bus_io.i_Grn1;
          blu_d = bus_io.i_Blu1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      blank_cnt_q <= 4'd0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      fs_q        <= 1'b0;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      vsync_q     <= bus_io.i_VSync;
      hsync_q     <= bus_io.i_HSync;
      fs_q        <= fs;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StOwn0:  bus_io.o_Gnt = 2'b01;
      StOwn1:  bus_io.o_Gnt = 2'b10;
      default: bus_io.o_Gnt = 2'b00;
    endcase
  end

  assign bus_io.o_HSync       = hsync_q;
  assign bus_io.o_VSync       = vsync_q;
  assign bus_io.o_Frame_Start = fs_q;
  assign bus_io.o_Red_Video   = red_q;
  assign bus_io.o_Grn_Video   = grn_q;
  assign bus_io.o_Blu_Video   = blu_q;

endmodule

// File: tb/tb_vga_source_arbiter.sv
// Scoreboard bench: two arbiters (one and zero blank frames) share stimulus; expected grant
// and pixels are queued per frame start and checked when the DUT pulses o_Frame_Start.
module tb_vga_source_arbiter;

  localparam int unsigned VW = 3;

  typedef struct {
    logic [1:0] gnt_a;
    logic [1:0] gnt_b;
    logic       hs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;

  vga_source_arbiter_if #(.VIDEO_WIDTH(VW)) bus_a ();
  vga_source_arbiter_if #(.VIDEO_WIDTH(VW)) bus_b ();

  vga_source_arbiter #(.VIDEO_WIDTH(VW), .BLANK_FRAMES(1)) dut_a (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus_io  (bus_a)
  );

  vga_source_arbiter #(.VIDEO_WIDTH(VW), .BLANK_FRAMES(0)) dut_b (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus_io  (bus_b)
  );

  always #20 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [8:0] pix(input logic [1:0] gnt, input logic hs);
    if (!hs) return 9'd0;
    if (gnt == 2'b01) return {3'd1, 3'd2, 3'd3};
    if (gnt == 2'b10) return {3'd6, 3'd5, 3'd4};
    return 9'd0;
  endfunction

  task automatic set_in(input logic hs, input logic vs, input logic [1:0] req);
    bus_a.i_HSync = hs;
    bus_a.i_VSync = vs;
    bus_a.i_Req   = req;
    bus_b.i_HSync = hs;
    bus_b.i_VSync = vs;
    bus_b.i_Req   = req;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic [1:0] req);
    @(posedge clk);
    #1;
    set_in(hs, vs, req);
  endtask

  // Seven-cycle frame: two cycles of vertical blank, frame start, four active cycles.
  // glitch masks request bits off for three cycles mid-frame.
  task automatic frame(input logic [1:0] req, input logic hs_fs, input logic [1:0] glitch,
                       input logic [1:0] ga, input logic [1:0] gb);
    exp_t e;
    drive(1'b0, 1'b0, req);
    drive(1'b0, 1'b0, req);
    e.gnt_a = ga;
    e.gnt_b = gb;
    e.hs    = hs_fs;
    sb_q.push_back(e);
    drive(hs_fs, 1'b1, req);
    drive(1'b1, 1'b1, req & ~glitch);
    drive(1'b0, 1'b1, req & ~glitch);
    drive(1'b1, 1'b1, req & ~glitch);
    drive(1'b0, 1'b1, req);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt_a"}, 32'(bus_a.o_Gnt), 32'd0);
    check({tag, "_hs_a"},  32'(bus_a.o_HSync), 32'd0);
    check({tag, "_vs_a"},  32'(bus_a.o_VSync), 32'd0);
    check({tag, "_fs_a"},  32'(bus_a.o_Frame_Start), 32'd0);
    check({tag, "_vid_a"},
          32'({bus_a.o_Red_Video, bus_a.o_Grn_Video, bus_a.o_Blu_Video}), 32'd0);
    check({tag, "_gnt_b"}, 32'(bus_b.o_Gnt), 32'd0);
    check({tag, "_vs_b"},  32'(bus_b.o_VSync), 32'd0);
    check({tag, "_vid_b"},
          32'({bus_b.o_Red_Video, bus_b.o_Grn_Video, bus_b.o_Blu_Video}), 32'd0);
  endtask

  // Monitor: every frame-start pulse consumes one expectation.
  always @(negedge clk) begin
    if (bus_a.o_Frame_Start === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected_fs: frame start with empty queue at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("fs_b",   32'(bus_b.o_Frame_Start), 32'd1);
        check("vs_a",   32'(bus_a.o_VSync), 32'd1);
        check("hs_a",   32'(bus_a.o_HSync), 32'(mon_e.hs));
        check("gnt_a",  32'(bus_a.o_Gnt), 32'(mon_e.gnt_a));
        check("gnt_b",  32'(bus_b.o_Gnt), 32'(mon_e.gnt_b));
        check("vid_a",  32'({bus_a.o_Red_Video, bus_a.o_Grn_Video, bus_a.o_Blu_Video}),
              32'(pix(mon_e.gnt_a, mon_e.hs)));
        check("vid_b",  32'({bus_b.o_Red_Video, bus_b.o_Grn_Video, bus_b.o_Blu_Video}),
              32'(pix(mon_e.gnt_b, mon_e.hs)));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 2'b00);
    bus_a.i_Red0 = 3'd1; bus_a.i_Grn0 = 3'd2; bus_a.i_Blu0 = 3'd3;
    bus_a.i_Red1 = 3'd6; bus_a.i_Grn1 = 3'd5; bus_a.i_Blu1 = 3'd4;
    bus_b.i_Red0 = 3'd1; bus_b.i_Grn0 = 3'd2; bus_b.i_Blu0 = 3'd3;
    bus_b.i_Red1 = 3'd6; bus_b.i_Grn1 = 3'd5; bus_b.i_Blu1 = 3'd4;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //     req    hs    glitch  gnt_a  gnt_b
    frame(2'b01, 1'b1, 2'b00, 2'b01, 2'b01);  // first grant from idle
    frame(2'b01, 1'b0, 2'b00, 2'b01, 2'b01);  // hsync low blanks video
    frame(2'b10, 1'b1, 2'b00, 2'b00, 2'b10);  // owner 0 releases
    frame(2'b10, 1'b1, 2'b00, 2'b10, 2'b10);  // blank expires
`ifdef VGA_ARB_PREEMPT_EN
    frame(2'b11, 1'b1, 2'b00, 2'b00, 2'b01);
    frame(2'b11, 1'b1, 2'b00, 2'b01, 2'b01);
`else
    frame(2'b11, 1'b1, 2'b00, 2'b10, 2'b10);
    frame(2'b11, 1'b1, 2'b00, 2'b10, 2'b10);
`endif
    frame(2'b00, 1'b1, 2'b00, 2'b00, 2'b00);  // owner leaves, nobody waiting
    frame(2'b11, 1'b1, 2'b01, 2'b01, 2'b01);  // req[0] glitch mid-frame
    frame(2'b11, 1'b1, 2'b00, 2'b01, 2'b01);
    frame(2'b01, 1'b0, 2'b00, 2'b01, 2'b01);
    frame(2'b10, 1'b1, 2'b00, 2'b00, 2'b10);  // A enters blank

    // Reset pulse while A is blanking.
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 2'b10);
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(posedge clk);
    #5;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_gnt_a", 32'(bus_a.o_Gnt), 32'd0);
      check("post_rst_gnt_b", 32'(bus_b.o_Gnt), 32'd0);
    end

    frame(2'b10, 1'b1, 2'b00, 2'b10, 2'b10);
    frame(2'b00, 1'b1, 2'b00, 2'b00, 2'b00);
    frame(2'b01, 1'b1, 2'b00, 2'b01, 2'b01);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
